// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared control constants for the multi-cycle RV32I sequencer.
// State codes, opcodes, datapath mux selects and the control bundle.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       retire;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the sequencer and the shared datapath.
// master = sequencer, slave = datapath.
interface mc_ctrl_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       branch;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic       retire;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, ir_write, reg_write,
    output mem_read, mem_write, branch,
    output adr_src, alu_src_a, alu_src_b,
    output alu_op, result_src, retire,
    output illegal, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, ir_write, reg_write,
    input  mem_read, mem_write, branch,
    input  adr_src, alu_src_a, alu_src_b,
    input  alu_op, result_src, retire,
    input  illegal, state
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational state/opcode decode for the multi-cycle sequencer.
// Produces the datapath control bundle and the next state.
module mc_ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  state_t     st,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl,
  output state_t     nxt
);

  // Per-state control outputs and next-state selection
  always_comb begin
    ctrl = '0;
    nxt  = st;
    case (st)
      S_RST: nxt = S_FETCH;
      S_FETCH: begin
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALU_ADD;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem_ready;
        ctrl.pc_write   = mem_ready;
        nxt = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        unique case (1'b1)
          (opcode == OP_LOAD),
          (opcode == OP_STORE):  nxt = S_MEMADR;
          (opcode == OP_R):      nxt = S_EXECR;
          (opcode == OP_I),
          (opcode == OP_LUI):    nxt = S_EXECI;
          (opcode == OP_BRANCH): nxt = S_BRANCH;
          (opcode == OP_JAL):    nxt = S_JAL;
          default:               nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        nxt = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        ctrl.adr_src  = 1'b1;
        ctrl.mem_read = 1'b1;
        nxt = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_MEM;
        ctrl.reg_write  = 1'b1;
        ctrl.retire     = 1'b1;
        nxt = S_FETCH;
      end
      S_MEMWRITE: begin
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.retire    = mem_ready;
        nxt = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALU_FUNCT;
        nxt = S_ALUWB;
      end
      S_EXECI: begin
        ctrl.alu_src_b = SRCB_IMM;
        if (opcode == OP_LUI) begin
          ctrl.alu_src_a = SRCA_ZERO;
          ctrl.alu_op    = ALU_ADD;
        end else begin
          ctrl.alu_src_a = SRCA_RS1;
          ctrl.alu_op    = ALU_FUNCT;
        end
        nxt = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.retire     = 1'b1;
        nxt = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALU_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.retire     = 1'b1;
        nxt = S_FETCH;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALU_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
        nxt = S_ALUWB;
      end
      S_TRAP: nxt = S_TRAP;
      default: nxt = S_FETCH;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: state register, sticky
// illegal flag and retired-instruction counter around the decode.
module mc_ctrl_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mc_ctrl_if.master            bus,
  output logic [INSTRET_W-1:0] instret
);

  state_t st;
  state_t nxt;
  ctrl_t  ctrl;
  logic   illegal;

  mc_ctrl_decode u_decode (
    .st        (st),
    .opcode    (bus.opcode),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl),
    .nxt       (nxt)
  );

  // State register; reset forces RST so every output drops at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= S_RST;
    else        st <= nxt;
  end

  // Sticky illegal flag, raised on entry to TRAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              illegal <= 1'b0;
    else if (nxt == S_TRAP)  illegal <= 1'b1;
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           instret <= '0;
    else if (ctrl.retire) instret <= instret + INSTRET_W'(1);
  end

  assign bus.pc_write   = ctrl.pc_write;
  assign bus.ir_write   = ctrl.ir_write;
  assign bus.reg_write  = ctrl.reg_write;
  assign bus.mem_read   = ctrl.mem_read;
  assign bus.mem_write  = ctrl.mem_write;
  assign bus.branch     = ctrl.branch;
  assign bus.adr_src    = ctrl.adr_src;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.result_src = ctrl.result_src;
  assign bus.retire     = ctrl.retire;
  assign bus.illegal    = illegal;
  assign bus.state      = st;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm: builds the expected cycle trace
// of each instruction and compares the controller against it.
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instret;

  mc_ctrl_if bus ();

  mc_ctrl_fsm #(.INSTRET_W(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .instret (instret)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] PCW = 8'h80;
  localparam logic [7:0] IRW = 8'h40;
  localparam logic [7:0] RW  = 8'h20;
  localparam logic [7:0] MR  = 8'h10;
  localparam logic [7:0] MW  = 8'h08;
  localparam logic [7:0] BR  = 8'h04;
  localparam logic [7:0] ADR = 8'h02;
  localparam logic [7:0] RET = 8'h01;

  localparam int K_LOAD = 0, K_STORE = 1, K_R = 2, K_I = 3;
  localparam int K_LUI = 4, K_BR = 5, K_JAL = 6, K_ILL = 7;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic [6:0] op;
    logic [7:0] en;
    logic [7:0] sel;
    logic       ill;
  } exp_t;

  exp_t        plan[$];
  int          n_chk = 0;
  int          n_err = 0;
  int unsigned model_cnt = 0;
  logic [6:0]  cur_op = 7'd0;
  logic        trap_seen = 1'b0;
  logic        fixed_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] sl(input logic [1:0] a, input logic [1:0] b,
                                    input logic [1:0] op, input logic [1:0] rs);
    return {a, b, op, rs};
  endfunction

  function automatic logic dc_rdy();
    return fixed_rdy ? 1'b1 : 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy,
                      input logic [7:0] en, input logic [7:0] sel);
    exp_t e;
    if (st == 4'd15) trap_seen = 1'b1;
    e.st = st; e.rdy = rdy; e.op = cur_op;
    e.en = en; e.sel = sel; e.ill = trap_seen;
    plan.push_back(e);
  endtask

  // Expected cycle trace of one instruction, from FETCH to its last cycle
  task automatic gen_instr(input int kind, input int wf, input int wm);
    logic [6:0] ops [8];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b0110111, 7'b1100011, 7'b1101111, 7'b0000000};
    cur_op = ops[kind];
    repeat (wf) push(4'd1, 1'b0, MR, sl(2'b00, 2'b10, 2'b00, 2'b10));
    push(4'd1, 1'b1, MR | IRW | PCW, sl(2'b00, 2'b10, 2'b00, 2'b10));
    push(4'd2, dc_rdy(), 8'h00, sl(2'b01, 2'b01, 2'b00, 2'b00));
    case (kind)
      K_LOAD: begin
        push(4'd3, dc_rdy(), 8'h00, sl(2'b10, 2'b01, 2'b00, 2'b00));
        repeat (wm) push(4'd4, 1'b0, MR | ADR, 8'h00);
        push(4'd4, 1'b1, MR | ADR, 8'h00);
        push(4'd5, dc_rdy(), RW | RET, sl(2'b00, 2'b00, 2'b00, 2'b01));
      end
      K_STORE: begin
        push(4'd3, dc_rdy(), 8'h00, sl(2'b10, 2'b01, 2'b00, 2'b00));
        repeat (wm) push(4'd6, 1'b0, MW | ADR, 8'h00);
        push(4'd6, 1'b1, MW | ADR | RET, 8'h00);
      end
      K_R: begin
        push(4'd7, dc_rdy(), 8'h00, sl(2'b10, 2'b00, 2'b10, 2'b00));
        push(4'd9, dc_rdy(), RW | RET, 8'h00);
      end
      K_I: begin
        push(4'd8, dc_rdy(), 8'h00, sl(2'b10, 2'b01, 2'b10, 2'b00));
        push(4'd9, dc_rdy(), RW | RET, 8'h00);
      end
      K_LUI: begin
        push(4'd8, dc_rdy(), 8'h00, sl(2'b11, 2'b01, 2'b00, 2'b00));
        push(4'd9, dc_rdy(), RW | RET, 8'h00);
      end
      K_BR: push(4'd10, dc_rdy(), BR | RET, sl(2'b10, 2'b00, 2'b01, 2'b00));
      K_JAL: begin
        push(4'd11, dc_rdy(), PCW, sl(2'b01, 2'b10, 2'b00, 2'b00));
        push(4'd9, dc_rdy(), RW | RET, 8'h00);
      end
      default: repeat (20) push(4'd15, dc_rdy(), 8'h00, 8'h00);
    endcase
  endtask

  // Drive each planned cycle and compare the controller mid-cycle
  task automatic run_plan();
    exp_t e;
    while (plan.size() > 0) begin
      e = plan.pop_front();
      @(negedge clk);
      bus.opcode    = e.op;
      bus.mem_ready = e.rdy;
      #1;
      check("state", 32'(bus.state), 32'(e.st));
      check("enables", 32'({bus.pc_write, bus.ir_write, bus.reg_write,
                            bus.mem_read, bus.mem_write, bus.branch,
                            bus.adr_src, bus.retire}), 32'(e.en));
      check("selects", 32'({bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                            bus.result_src}), 32'(e.sel));
      check("illegal", 32'(bus.illegal), 32'(e.ill));
      check("instret", instret, model_cnt);
      if ((e.en & RET) != 8'h00) model_cnt++;
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    push(4'd0, dc_rdy(), 8'h00, 8'h00);
  endtask

  initial begin
    bus.opcode    = 7'd0;
    bus.mem_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_mem_read", 32'(bus.mem_read), 32'd0);
    check("rst_instret", instret, 32'd0);

    fixed_rdy = 1'b1;
    release_reset();
    gen_instr(K_R, 0, 0);
    run_plan();
    fixed_rdy = 1'b0;

    gen_instr(K_LOAD, 2, 3);
    gen_instr(K_STORE, 0, 1);
    gen_instr(K_BR, 0, 0);
    gen_instr(K_JAL, 0, 0);
    run_plan();

    for (int i = 0; i < 60; i++) begin
      gen_instr(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
      run_plan();
    end

    gen_instr(K_ILL, 1, 0);
    run_plan();

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("trap_rst_illegal", 32'(bus.illegal), 32'd0);
    check("trap_rst_state", 32'(bus.state), 32'd0);
    model_cnt = 0;
    trap_seen = 1'b0;
    release_reset();
    gen_instr(K_LOAD, 0, 0);
    cur_op = 7'b0100011;
    push(4'd1, 1'b1, MR | IRW | PCW, sl(2'b00, 2'b10, 2'b00, 2'b10));
    push(4'd2, 1'b0, 8'h00, sl(2'b01, 2'b01, 2'b00, 2'b00));
    push(4'd3, 1'b0, 8'h00, sl(2'b10, 2'b01, 2'b00, 2'b00));
    push(4'd6, 1'b0, MW | ADR, 8'h00);
    run_plan();
    rst_n = 1'b0;
    #1;
    check("midrst_mem_write", 32'(bus.mem_write), 32'd0);
    check("midrst_retire", 32'(bus.retire), 32'd0);
    check("midrst_state", 32'(bus.state), 32'd0);
    check("midrst_instret", instret, 32'd0);
    check("midrst_illegal", 32'(bus.illegal), 32'd0);
    model_cnt = 0;
    repeat (2) @(negedge clk);
    release_reset();
    gen_instr(K_R, 0, 0);
    run_plan();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
